// File: rtl/seq_gen_moore.sv
// Serial pattern generator: loads a pattern and shifts it out MSB first.
// Define SEQ_GEN_REPEAT_EN to add repeat_cnt and the GAP state.
module seq_gen_moore #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
`ifdef SEQ_GEN_REPEAT_EN
    input  logic [CNT_W-1:0] repeat_cnt,
`endif
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    typedef logic [CNT_W-1:0] cnt_t;

`ifdef SEQ_GEN_REPEAT_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd3
    } state_t;
`endif

    localparam logic [LEN_W-1:0] FULL = LEN_W'(WIDTH);

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] save_pat, save_pat_n;
    logic [LEN_W-1:0] bit_cnt, bit_cnt_n;
    logic [LEN_W-1:0] save_len, save_len_n;
    logic [LEN_W-1:0] len_eff;
    logic [WIDTH-1:0] load_pat;
`ifdef SEQ_GEN_REPEAT_EN
    cnt_t             rep_left, rep_left_n;
`endif

    // Left-justify so pattern[len_eff-1] lands in the MSB.
    assign len_eff  = (len == '0 || len > FULL) ? FULL : len;
    assign load_pat = pattern << (FULL - len_eff);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            save_pat <= '0;
            bit_cnt  <= '0;
            save_len <= '0;
`ifdef SEQ_GEN_REPEAT_EN
            rep_left <= '0;
`endif
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            save_pat <= save_pat_n;
            bit_cnt  <= bit_cnt_n;
            save_len <= save_len_n;
`ifdef SEQ_GEN_REPEAT_EN
            rep_left <= rep_left_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        save_pat_n = save_pat;
        bit_cnt_n  = bit_cnt;
        save_len_n = save_len;
`ifdef SEQ_GEN_REPEAT_EN
        rep_left_n = rep_left;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n    = SEND;
                    shreg_n    = load_pat;
                    save_pat_n = load_pat;
                    bit_cnt_n  = len_eff;
                    save_len_n = len_eff;
`ifdef SEQ_GEN_REPEAT_EN
                    rep_left_n = repeat_cnt;
`endif
                end
            end
            SEND: begin
                shreg_n   = {shreg[WIDTH-2:0], 1'b0};
                bit_cnt_n = bit_cnt - LEN_W'(1);
                if (bit_cnt == LEN_W'(1)) begin
`ifdef SEQ_GEN_REPEAT_EN
                    state_n = (rep_left != '0) ? GAP : DONE;
`else
                    state_n = DONE;
`endif
                end
            end
`ifdef SEQ_GEN_REPEAT_EN
            GAP: begin
                shreg_n    = save_pat;
                bit_cnt_n  = save_len;
                rep_left_n = rep_left - cnt_t'(1);
                state_n    = SEND;
            end
`endif
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign out       = (state == SEND) && shreg[WIDTH-1];
    assign out_valid = (state == SEND);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_seq_gen_moore.sv
// Randomized/directed bench for seq_gen_moore against a per-cycle
// expected-output list built from the pattern/len/repeat rules.
module tb_seq_gen_moore;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] repeat_cnt;
    logic       out;
    logic       out_valid;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    seq_gen_moore #(.WIDTH(8), .LEN_W(4), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pattern   (pattern),
        .len       (len),
`ifdef SEQ_GEN_REPEAT_EN
        .repeat_cnt(repeat_cnt),
`endif
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observed vector is {out, out_valid, busy, done}.
    task automatic chk(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {out, out_valid, busy, done};
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected per-cycle outputs from the cycle after acceptance onward:
    // copies of the bit stream separated by gaps, then done, then idle.
    task automatic run_tx(input logic [7:0] p, input logic [3:0] l,
                          input logic [3:0] r, input int poke,
                          input int abort_at, input string tag);
        logic [3:0] q[$];
        int le;
        le = (l == 0 || l > 8) ? 8 : int'(l);
        for (int c = 0; c <= int'(r); c++) begin
            for (int i = le - 1; i >= 0; i--)
                q.push_back({p[i], 1'b1, 1'b1, 1'b0});
            if (c < int'(r)) q.push_back(4'b0010);
        end
        q.push_back(4'b0011);
        q.push_back(4'b0000);

        pattern    = p;
        len        = l;
        repeat_cnt = r;
        start      = 1'b1;
        step();
        for (int idx = 0; idx < q.size(); idx++) begin
            pattern    = 8'($urandom);
            len        = 4'($urandom);
            repeat_cnt = 4'($urandom);
            start      = (idx == poke);
            if (idx == abort_at) begin
                chk($sformatf("%s_pre_abort", tag), q[idx]);
                reset = 1'b1;
                step();
                start = 1'b0;
                chk($sformatf("%s_abort", tag), 4'b0000);
                reset = 1'b0;
                step();
                chk($sformatf("%s_no_done", tag), 4'b0000);
                return;
            end
            chk($sformatf("%s_c%0d", tag, idx + 1), q[idx]);
            if (idx < q.size() - 1) step();
        end
    endtask

    initial begin
        logic [3:0] rr;
        reset      = 1'b1;
        start      = 1'b0;
        pattern    = 8'h00;
        len        = 4'd0;
        repeat_cnt = 4'd0;
        step();
        step();
        chk("reset", 4'b0000);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("idle%0d", i), 4'b0000);
        end

        run_tx(8'hA5, 4'd8, 4'd0, -1, -1, "a5");
        run_tx(8'h03, 4'd2, 4'd0, -1, -1, "two_ones");
        run_tx(8'h80, 4'd0, 4'd0, -1, -1, "len0");
        run_tx(8'hA5, 4'd8, 4'd0, 2, -1, "ignore_ff");
        run_tx(8'hFF, 4'd8, 4'd0, -1, -1, "ff");
        run_tx(8'hA5, 4'd8, 4'd0, -1, 3, "abort");
        run_tx(8'hA5, 4'd8, 4'd0, -1, -1, "after_abort");
        run_tx(8'h5A, 4'd12, 4'd0, -1, -1, "len12");
        run_tx(8'h01, 4'd1, 4'd0, -1, -1, "len1");
`ifdef SEQ_GEN_REPEAT_EN
        run_tx(8'h0B, 4'd4, 4'd2, -1, -1, "rep0b");
`endif

        for (int t = 0; t < 30; t++) begin
`ifdef SEQ_GEN_REPEAT_EN
            rr = 4'($urandom_range(0, 3));
`else
            rr = 4'd0;
`endif
            run_tx(8'($urandom), 4'($urandom), rr,
                   int'($urandom_range(0, 12)) - 2, -1,
                   $sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_gen_moore.md
# seq_gen_moore

Serial bit-sequence generator for the FSM block family. It loads a parallel pattern and shifts it out one bit per clock, MSB first, as a serial stream with a valid strobe. The stream is the stimulus/transmit side for the serial sequence detectors, such as the two-or-more-ones Moore detector. Control is a Moore FSM with a start/busy/done handshake and an optional repeat count.

## Interface
- WIDTH, 8, maximum pattern length in bits (≥2)
- LEN_W, 4, width of `len`; must satisfy 2^LEN_W > WIDTH
- CNT_W, 4, width of `repeat_cnt` (used only with SEQ_GEN_REPEAT_EN)

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  transmit request; accepted only on an edge where state is IDLE
- pattern  input  WIDTH  bits to send; sampled on accepted start
- len  input  LEN_W  number of bits to send, 1..WIDTH; 0 or >WIDTH is treated as WIDTH; sampled on accepted start
- repeat_cnt  input  CNT_W  extra repetitions after the first; sampled on accepted start (present only with SEQ_GEN_REPEAT_EN)
- out  output  1  serial data bit; 0 whenever out_valid=0
- out_valid  output  1  high while `out` carries a pattern bit
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse marking transmission complete

## Operation
- States: IDLE, SEND, GAP (repeat build only), DONE. All outputs are decoded from registered state and datapath registers only (Moore); no input reaches an output combinationally.
- IDLE:
  - start=1 → SEND.
  - Load shift register with pattern << (WIDTH−len_eff), so `pattern[len_eff−1]` is the first bit sent.
  - bit_cnt ← len_eff; rep_left ← repeat_cnt.
  - Save pattern/len_eff for reloads.
- SEND:
  - out = shreg[WIDTH−1], out_valid=1.
  - Each edge: shift left by 1, fill 0, bit_cnt−1.
  - On the edge where bit_cnt==1: rep_left≠0 → GAP; otherwise → DONE.
- GAP:
  - One cycle, out=0, out_valid=0.
  - Reload shreg/bit_cnt from the saved values; rep_left−1 → SEND.
- DONE: one cycle, done=1, busy=1 → IDLE.
- start outside IDLE (including DONE) is ignored. start held high continuously re-triggers on each visit to IDLE.
- `pattern`, `len` and `repeat_cnt` changes after acceptance have no effect on the transmission in progress.
- Reset:
  - Values: state=IDLE, shreg=0, bit_cnt=0, rep_left=0, out=0, out_valid=0, busy=0, done=0.
  - Reset has priority over start.
  - Reset mid-transmission aborts with no done pulse.

## Timing
- start accepted at edge k → first bit on `out` during cycle k+1.
- Bits occupy cycles k+1..k+len_eff; done high in cycle k+len_eff+1; IDLE (busy=0) in cycle k+len_eff+2. The earliest next acceptance is the edge ending that IDLE cycle.
- With repeats r:
  - Total output span is (r+1)·len_eff + r cycles, including one GAP cycle between copies.
  - done follows in the next cycle.
- Reset asserted at edge j → all outputs at reset values in cycle j+1.

## Configuration
- SEQ_GEN_REPEAT_EN defined:
  - The `repeat_cnt` port, rep_left register and GAP state exist.
  - The pattern is sent repeat_cnt+1 times, with one idle gap cycle between copies.
- Not defined:
  - `repeat_cnt`, rep_left and GAP are absent.
  - Every accepted start sends the pattern exactly once (SEND → DONE); timing is otherwise identical.

## Test plan
- Reset for 2 cycles, then release → out=0, out_valid=0, busy=0, done=0. start=0 for 5 cycles keeps all outputs at 0.
- pattern=8'hA5, len=8, start pulsed at edge 0:
  - out=1,0,1,0,0,1,0,1 in cycles 1–8 with out_valid=1.
  - done=1 in cycle 9; busy=0 in cycle 10.
- pattern=8'h03, len=2 (two-ones detector stimulus) → out=1,1 in cycles 1–2, done in cycle 3. len=0 with pattern=8'h80 → 1 then seven 0s, i.e. treated as 8 bits.
- start re-asserted with pattern=8'hFF during cycle 3 of an 8'hA5 transmission → ignored, A5 stream unchanged. The new pattern goes out only when start is high again in IDLE.
- Reset asserted during the 4th bit of 8'hA5 → next cycle out=0, out_valid=0, busy=0; no done pulse. A following start sends the full pattern from bit 1.
- SEQ_GEN_REPEAT_EN, pattern=8'h0B, len=4, repeat_cnt=2:
  - out = 1011, gap, 1011, gap, 1011 across cycles 1–14, with out_valid=0 in cycles 5 and 10.
  - done in cycle 15.
